// File: rtl/memb_ctrl_pkg.sv
// Shared types and sizing helpers for the memB skew-buffer sequencer.
package memb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int total_pulses(input int dim);
    return 3 * dim - 1;
  endfunction

  function automatic int cnt_w(input int dim);
    return $clog2(3 * dim);
  endfunction

endpackage

// File: rtl/memb_ctrl_valid_dec.sv
// Per-column valid window decode: column i carries a real B element while
// DIM+i <= c <= 2*DIM+i-1 and the sequencer is loading or draining.
module memb_ctrl_valid_dec
  import memb_ctrl_pkg::*;
#(
  parameter int DIM = 8,
  parameter int CW  = cnt_w(DIM)
) (
  input  logic [CW-1:0]  c_i,
  input  state_e         state_i,
  output logic [DIM-1:0] col_valid_o
);

  always_comb begin
    col_valid_o = '0;
    if (state_i == LOAD || state_i == DRAIN) begin
      for (int i = 0; i < DIM; i++) begin
        if ((int'(c_i) >= DIM + i) && (int'(c_i) <= 2 * DIM + i - 1)) begin
          col_valid_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/memb_ctrl.sv
// Sequencer for the B-operand skew buffer: accepts DIM rows, drains the skew
// with zeros, and qualifies each column. Optional MEMB_CTRL_PERF_EN adds stall_cnt.
module memb_ctrl
  import memb_ctrl_pkg::*;
#(
  parameter int BITS_AB = 32,
  parameter int DIM     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           row_valid,
  input  logic [DIM-1:0][BITS_AB-1:0]    row_data,
  output logic                           row_ready,
  input  logic                           step_ready,
  output logic                           b_en,
  output logic [DIM-1:0][BITS_AB-1:0]    b_in,
  output logic [DIM-1:0]                 col_valid,
  output logic                           busy,
  output logic                           done
`ifdef MEMB_CTRL_PERF_EN
  , output logic [31:0]                  stall_cnt
`endif
);

  localparam int CW    = cnt_w(DIM);
  localparam int TOTAL = total_pulses(DIM);
  localparam logic [CW-1:0] LAST_ROW   = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_PULSE = CW'(TOTAL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] c_q, c_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
    end
  end

  // c counts completed b_en pulses; every pulse advances memB by one row.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    row_ready = 1'b0;
    b_en      = 1'b0;
    b_in      = '0;
    unique case (state_q)
      IDLE: begin
        c_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        row_ready = step_ready;
        b_en      = row_valid & step_ready;
        b_in      = row_data;
        if (b_en) begin
          c_d = c_q + 1'b1;
          if (c_q == LAST_ROW) state_d = DRAIN;
        end
      end
      DRAIN: begin
        b_en = step_ready;
        if (b_en) begin
          c_d = c_q + 1'b1;
          if (c_q == LAST_PULSE) state_d = DONE;
        end
      end
      DONE: begin
        c_d     = '0;
        state_d = IDLE;
      end
      default: begin
        c_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  memb_ctrl_valid_dec #(
    .DIM (DIM),
    .CW  (CW)
  ) u_valid_dec (
    .c_i         (c_q),
    .state_i     (state_q),
    .col_valid_o (col_valid)
  );

`ifdef MEMB_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Counts LOAD/DRAIN cycles without a step; kept after completion for readout.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if ((state_q == LOAD || state_q == DRAIN) && !b_en && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_memb_ctrl.sv
// Scoreboard bench for memb_ctrl (DIM=8) with a behavioural memB skew model;
// checks stall_cnt as well when MEMB_CTRL_PERF_EN is defined.
module tb_memb_ctrl;

  localparam int BITS = 32;
  localparam int DIM  = 8;
  localparam int W    = DIM * BITS;

  typedef struct packed {
    int                        k;
    logic [DIM-1:0][BITS-1:0]  bin;
    logic [DIM-1:0]            cv;
  } pulse_t;

  typedef struct packed {
    int cyc;
    int stall;
  } done_t;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic                      row_valid;
  logic [DIM-1:0][BITS-1:0]  row_data;
  logic                      row_ready;
  logic                      step_ready;
  logic                      b_en;
  logic [DIM-1:0][BITS-1:0]  b_in;
  logic [DIM-1:0]            col_valid;
  logic                      busy;
  logic                      done;
`ifdef MEMB_CTRL_PERF_EN
  logic [31:0]               stall_cnt;
`endif

  int     vectors;
  int     miscompares;
  int     cyc;
  pulse_t pulseQ[$];
  done_t  doneQ[$];

  logic [BITS-1:0] sr [DIM][2*DIM];
  logic [DIM-1:0][BITS-1:0] bout;

  memb_ctrl #(
    .BITS_AB (BITS),
    .DIM     (DIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_ready  (row_ready),
    .step_ready (step_ready),
    .b_en       (b_en),
    .b_in       (b_in),
    .col_valid  (col_valid),
    .busy       (busy),
    .done       (done)
`ifdef MEMB_CTRL_PERF_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memB model: column i is a DIM+i stage shift register sharing rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++)
        for (int s = 0; s < 2 * DIM; s++) sr[i][s] <= '0;
    end else if (b_en) begin
      for (int i = 0; i < DIM; i++) begin
        for (int s = 1; s < DIM + i; s++) sr[i][s] <= sr[i][s-1];
        sr[i][0] <= b_in[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIM; i++) bout[i] = sr[i][DIM+i-1];
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DIM-1:0][BITS-1:0] rowVal(input int r);
    logic [DIM-1:0][BITS-1:0] v;
    for (int j = 0; j < DIM; j++) v[j] = BITS'(8 * r + j);
    return v;
  endfunction

  // Expected pulse stream: rows 0..7 then zeros, column i valid for k in [8+i, 15+i].
  task automatic pushExpected(input int doneCyc, input int stalls);
    pulse_t p;
    done_t  d;
    for (int k = 0; k < 3 * DIM - 1; k++) begin
      p.k   = k;
      p.bin = (k < DIM) ? rowVal(k) : '0;
      for (int i = 0; i < DIM; i++) p.cv[i] = (k >= DIM + i) && (k <= 2 * DIM + i - 1);
      pulseQ.push_back(p);
    end
    d.cyc   = doneCyc;
    d.stall = stalls;
    doneQ.push_back(d);
  endtask

  // Monitor: pops one expectation per b_en pulse and per done pulse.
  always @(negedge clk) begin
    pulse_t e;
    done_t  d;
    logic [DIM-1:0][BITS-1:0] expBout;
    logic [DIM-1:0][BITS-1:0] actBout;
    if (rst_n && b_en) begin
      if (pulseQ.size() == 0) begin
        checkOutput("unexpected b_en pulse", W'(1), W'(0));
      end else begin
        e = pulseQ.pop_front();
        checkOutput("b_in", W'(b_in), W'(e.bin));
        checkOutput("col_valid", W'(col_valid), W'(e.cv));
        expBout = '0;
        actBout = '0;
        for (int i = 0; i < DIM; i++) begin
          if (e.cv[i]) begin
            expBout[i] = BITS'(8 * (e.k - DIM - i) + i);
            actBout[i] = bout[i];
          end
        end
        checkOutput("Bout", W'(actBout), W'(expBout));
      end
    end
    if (rst_n && done) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected done", W'(1), W'(0));
      end else begin
        d = doneQ.pop_front();
        checkOutput("done cycle", W'(cyc), W'(d.cyc));
        checkOutput("pulses left at done", W'(pulseQ.size()), W'(0));
`ifdef MEMB_CTRL_PERF_EN
        checkOutput("stall_cnt at done", W'(stall_cnt), W'(d.stall));
`endif
      end
    end
  end

  task automatic applyStimulus(input int gapLen, input int stallLen, input bit pokeStart, input int rstAt);
    int  accepted;
    int  pulses;
    int  gapLeft;
    int  stallLeft;
    int  guard;
    bit  finished;
    @(posedge clk); #1;
    pushExpected(cyc + 3 * DIM + gapLen + stallLen, gapLen + stallLen);
    start      = 1'b1;
    step_ready = 1'b1;
    row_valid  = pokeStart;
    row_data   = rowVal(0);
    @(negedge clk);
    checkOutput("row_ready in IDLE", W'(row_ready), W'(0));
    checkOutput("b_en in IDLE", W'(b_en), W'(0));
    @(posedge clk); #1;
    start     = 1'b0;
    accepted  = 0;
    pulses    = 0;
    gapLeft   = gapLen;
    stallLeft = stallLen;
    guard     = 0;
    finished  = 1'b0;
    while (!finished && guard < 200) begin
      step_ready = !(pulses == 12 && stallLeft > 0);
      row_valid  = (accepted < DIM) && !(accepted == 5 && gapLeft > 0);
      row_data   = rowVal((accepted < DIM) ? accepted : 0);
      start      = pokeStart && (pulses == 3 || pulses == 3 * DIM - 1);
      if (rstAt >= 0 && pulses == rstAt) begin
        rst_n = 1'b0;
        start = 1'b0;
        row_valid = 1'b0;
        #1;
        checkOutput("outputs in reset",
                    W'({row_ready, b_en, busy, done, col_valid, (|b_in)}), W'(0));
        pulseQ.delete();
        doneQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("busy after reset", W'(busy), W'(0));
        finished = 1'b1;
      end else begin
        @(negedge clk);
        if (!step_ready) begin
          checkOutput("drain stall b_en", W'(b_en), W'(0));
          checkOutput("drain stall b_in", W'(b_in), W'(0));
          checkOutput("drain stall col_valid", W'(col_valid), W'(8'h1F));
          stallLeft--;
        end else if (!row_valid && accepted == 5) begin
          checkOutput("gap b_en", W'(b_en), W'(0));
          checkOutput("gap col_valid", W'(col_valid), W'(0));
          checkOutput("gap busy", W'(busy), W'(1));
          gapLeft--;
        end
        if (b_en) pulses++;
        if (row_valid && row_ready) accepted++;
        if (done) finished = 1'b1;
        @(posedge clk); #1;
        guard++;
      end
    end
    if (!finished) checkOutput("timeout waiting for done", W'(0), W'(1));
    start     = 1'b0;
    row_valid = 1'b0;
    if (pokeStart) begin
      row_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checkOutput("idle row_ready with row_valid", W'(row_ready), W'(0));
        checkOutput("idle b_en with row_valid", W'(b_en), W'(0));
        checkOutput("idle busy after DONE start", W'(busy), W'(0));
        @(posedge clk); #1;
      end
      row_valid = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    row_valid   = 1'b0;
    row_data    = '0;
    step_ready  = 1'b1;
    #3;
    checkOutput("reset outputs",
                W'({row_ready, b_en, busy, done, col_valid, (|b_in)}), W'(0));
`ifdef MEMB_CTRL_PERF_EN
    checkOutput("reset stall_cnt", W'(stall_cnt), W'(0));
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(0, 0, 1'b0, -1);
    applyStimulus(3, 0, 1'b0, -1);
    applyStimulus(0, 2, 1'b0, -1);
    applyStimulus(0, 0, 1'b1, -1);
    applyStimulus(0, 0, 1'b0, 10);
    applyStimulus(0, 0, 1'b0, -1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pulse queue empty at end", W'(pulseQ.size()), W'(0));
    checkOutput("done queue empty at end", W'(doneQ.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
